alu_sched: RTL and testbench
============================

# alu_sched

Multi-cycle issue controller that shares one combinational `alu` instance between `NREQ` requesters, such as the decode stage and a writeback/fixup path. It arbitrates requests round-robin, latches the winner's operands, and holds them stable for an opcode-dependent number of cycles. It then captures the `alu` result, patches divide-by-zero and illegal-opcode cases, and returns the result to the issuing requester through a valid/ready response channel.

## Interface
- `NREQ`, 2, number of requesters (2..8); `IDW = $clog2(NREQ)` is a localparam (min 1).
- `MUL_LAT`, 3, cycles operands are held for MUL (≥1).
- `DIV_LAT`, 8, cycles operands are held for DIV/REM (≥1).
- `clk`  in  1  clock; everything is synchronous to its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit is high.
- `req_opcode`  in  NREQ×4  `alu` opcode per requester.
- `req_value1`, `req_value2`  in  NREQ×64  signed operands.
- `req_imm`  in  NREQ×32  signed immediate.
- `req_shamt`  in  NREQ×6  shift amount.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester that issued the op.
- `rsp_result`  out  64  result.
- `rsp_illegal`  out  1  opcode was 12..15.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - The round-robin winner among `req_valid` bits gets its `req_ready` bit set combinationally.
  - Search order starts at `rr_ptr`.
  - On `req_valid[i] & req_ready[i]`:
    - latch opcode, operands and id;
    - set `rr_ptr = (i+1) % NREQ`;
    - load `cnt = lat(opcode) - 1`;
    - go to EXEC.
- **EXEC**
  - The latched fields drive the `alu` ports.
  - `cnt` decrements each cycle.
  - When `cnt == 0`, register the patched result, id and illegal flag, then go to RESP.
- **RESP**
  - `rsp_valid = 1`; the response is held stable until `rsp_ready`.
  - On the handshake, go to IDLE.
  - No new request is accepted in the handshake cycle.
- Latency function `lat(op)`:
  - MUL: `MUL_LAT`.
  - DIV, REM: `DIV_LAT`.
  - All other opcodes: 1.
- Operand rule (patch logic mirrors the `alu` operand selection):
  - `req_imm != 0` → second operand = sign-extended imm.
  - else `req_shamt != 0` → second operand = zero-extended shamt.
  - else second operand = value2.
- Result patching, applied on capture:
  - DIV with second operand 0 → `64'hFFFF_FFFF_FFFF_FFFF`.
  - REM with second operand 0 → value1.
  - DIV with most-negative value1 and second operand −1 → value1.
  - REM with most-negative value1 and second operand −1 → 0.
  - NOTHING (0) → result 0, `rsp_illegal = 0`.
  - Opcodes 12..15 → result 0, `rsp_illegal = 1`; the `alu` output is ignored.
- Arbitration:
  - A requester that keeps `req_valid` high is granted within NREQ grants.
  - A requester may drop `req_valid` before it is accepted without any effect.
- **Reset** (asserted at any time, including mid-EXEC or mid-RESP):
  - state = IDLE, `rr_ptr = 0`, `cnt = 0`;
  - the in-flight op is dropped and no response is produced.

## Timing
- Reset values: `req_ready = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_result = 0`, `rsp_illegal = 0`, `busy = 0`.
- `req_ready` is forced to 0 while `reset` is high.
- Accept edge at the end of cycle c → EXEC occupies cycles c+1..c+lat → `rsp_valid` first high in cycle c+lat+1.
- Minimum issue interval is lat+2 cycles, with `rsp_ready` held high.
- `req_ready` depends combinationally on `req_valid` and the state. There is no combinational path from `rsp_ready` to `req_ready`.
- `rsp_*` outputs are registered. They change only on capture, and `rsp_valid` also on handshake.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams NOTHING=0 … ARTHRIGHT=12;
  - the state enum;
  - a `lat_f(opcode, MUL_LAT, DIV_LAT)` function;
  - a `is_illegal_f(opcode)` function.
- The `alu` is instantiated unchanged.
- One sub-module: `rr_arbiter #(NREQ)`.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `grant`, encoded `grant_idx`.
  - Purely combinational.

## Test plan
1. Reset, then req0 issues ADD 5+7 (imm=0, shamt=0), `rsp_ready` held 1 → `rsp_valid` two cycles after accept, result 12, `rsp_id` 0.
2. req0 and req1 both valid continuously with ADD, `NREQ=2` → grants alternate 0,1,0,1; no grant is starved.
3. MUL −3×4 with `MUL_LAT=3`, `rsp_ready=0` for 5 cycles after valid → result −12, held stable until `rsp_ready`; `busy` stays high throughout.
4. DIV 10/0 → result all-ones; REM 10/0 → 10; DIV `64'h8000…0` / −1 → `64'h8000…0`; each op occupies EXEC for 8 cycles.
5. Opcode 13 → result 0, `rsp_illegal = 1`, latency 1; NOTHING → result 0, `rsp_illegal = 0`.
6. Assert `reset` during cycle 4 of a DIV → no response appears; after release, a new ADD 1+1 is granted to req0 and returns 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, scheduler state type and the latency/legality/operand helpers
// used by both the alu and the issue controller.
package alu_pkg;

    localparam logic [3:0] NOTHING   = 4'd0;
    localparam logic [3:0] ADD       = 4'd1;
    localparam logic [3:0] SUB       = 4'd2;
    localparam logic [3:0] MUL       = 4'd3;
    localparam logic [3:0] DIV       = 4'd4;
    localparam logic [3:0] REM       = 4'd5;
    localparam logic [3:0] AND       = 4'd6;
    localparam logic [3:0] OR        = 4'd7;
    localparam logic [3:0] XOR       = 4'd8;
    localparam logic [3:0] SLT       = 4'd9;
    localparam logic [3:0] SHLEFT    = 4'd10;
    localparam logic [3:0] LOGRIGHT  = 4'd11;
    localparam logic [3:0] ARTHRIGHT = 4'd12;

    localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic int lat_f(input logic [3:0] op, input int mul_lat, input int div_lat);
        case (op)
            MUL:      return mul_lat;
            DIV, REM: return div_lat;
            default:  return 1;
        endcase
    endfunction

    function automatic logic is_illegal_f(input logic [3:0] op);
        return op >= 4'd12;
    endfunction

    // Second operand: a non-zero immediate wins, then a non-zero shift amount.
    function automatic logic [63:0] operand_f(input logic [63:0] value2, input logic [31:0] imm,
                                              input logic [5:0] shamt);
        if (imm != '0)
            return {{32{imm[31]}}, imm};
        else if (shamt != '0)
            return {58'd0, shamt};
        else
            return value2;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 64-bit alu; the divider is fed a safe divisor so the
// zero and overflow cases never reach the division operator.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [63:0] value1,
    input  logic [63:0] value2,
    input  logic [31:0] imm,
    input  logic [5:0]  shamt,
    output logic [63:0] result
);

    logic signed [63:0] a;
    logic signed [63:0] b;
    logic signed [63:0] safe_b;

    // NOTE: every signal written in an always_comb gets a value on every path first, or a latch is inferred.
    always_comb begin
        a      = value1;
        b      = operand_f(value2, imm, shamt);
        safe_b = (b == '0 || (value1 == INT64_MIN && b == '1)) ? 64'sd1 : b;
        result = '0;
        case (opcode)
            ADD:       result = a + b;
            SUB:       result = a - b;
            MUL:       result = a * b;
            DIV:       result = a / safe_b;
            REM:       result = a % safe_b;
            AND:       result = a & b;
            OR:        result = a | b;
            XOR:       result = a ^ b;
            SLT:       result = {63'd0, a < b};
            SHLEFT:    result = a << b[5:0];
            LOGRIGHT:  result = a >> b[5:0];
            ARTHRIGHT: result = a >>> b[5:0];
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    int             idx;
    logic [IDW-1:0] sel;
    logic           found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            sel = idx[IDW-1:0];
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Multi-cycle issue controller sharing one alu between NREQ requesters:
// round-robin accept, opcode-dependent hold, patched registered response.
module alu_sched
    import alu_pkg::*;
#(
    parameter  int NREQ    = 2,
    parameter  int MUL_LAT = 3,
    parameter  int DIV_LAT = 8,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][3:0]  req_opcode,
    input  logic [NREQ-1:0][63:0] req_value1,
    input  logic [NREQ-1:0][63:0] req_value2,
    input  logic [NREQ-1:0][31:0] req_imm,
    input  logic [NREQ-1:0][5:0]  req_shamt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [63:0]           rsp_result,
    output logic                  rsp_illegal,
    output logic                  busy
);

    localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  op_id;
    logic [CW-1:0]   cnt;
    logic [3:0]      op_code;
    logic [63:0]     op_v1;
    logic [63:0]     op_v2;
    logic [31:0]     op_imm;
    logic [5:0]      op_sh;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [63:0]     alu_result;
    logic [63:0]     opnd2;
    logic [63:0]     patched;
    logic            accept;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    alu u_alu (
        .opcode (op_code),
        .value1 (op_v1),
        .value2 (op_v2),
        .imm    (op_imm),
        .shamt  (op_sh),
        .result (alu_result)
    );

    // Grant only from IDLE, so a response handshake never shares a cycle with an accept.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        opnd2   = operand_f(op_v2, op_imm, op_sh);
        patched = alu_result;
        if (is_illegal_f(op_code) || op_code == NOTHING) begin
            patched = '0;
        end else if (op_code == DIV) begin
            if (opnd2 == '0)
                patched = '1;
            else if (op_v1 == INT64_MIN && opnd2 == '1)
                patched = op_v1;
        end else if (op_code == REM) begin
            if (opnd2 == '0)
                patched = op_v1;
            else if (op_v1 == INT64_MIN && opnd2 == '1)
                patched = '0;
        end
    end

    // NOTE: operand latches carry no reset; they are only read after an accept has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_code <= req_opcode[grant_idx];
            op_v1   <= req_value1[grant_idx];
            op_v2   <= req_value2[grant_idx];
            op_imm  <= req_imm[grant_idx];
            op_sh   <= req_shamt[grant_idx];
            op_id   <= grant_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        cnt    <= CW'(lat_f(req_opcode[grant_idx], MUL_LAT, DIV_LAT) - 1);
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_result  <= patched;
                        rsp_id      <= op_id;
                        rsp_illegal <= is_illegal_f(op_code);
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed vector table, arbitration and
// reset sequences, and random ops against an arithmetic reference model.
module tb_alu_sched;
    import alu_pkg::*;

    localparam int NREQ    = 2;
    localparam int IDW     = 1;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][3:0]  req_opcode;
    logic [NREQ-1:0][63:0] req_value1;
    logic [NREQ-1:0][63:0] req_value2;
    logic [NREQ-1:0][31:0] req_imm;
    logic [NREQ-1:0][5:0]  req_shamt;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [63:0]           rsp_result;
    logic                  rsp_illegal;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [31:0] imm;
        logic [5:0]  sh;
        int          rdly;
        logic [63:0] exp;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    alu_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_value1  (req_value1),
        .req_value2  (req_value2),
        .req_imm     (req_imm),
        .req_shamt   (req_shamt),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_illegal (rsp_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: results straight from the opcode definitions.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] v1,
                                               input logic [63:0] v2, input logic [31:0] imm,
                                               input logic [5:0] sh);
        logic signed [63:0] a;
        logic signed [63:0] b;
        a = v1;
        if (imm != 0)     b = {{32{imm[31]}}, imm};
        else if (sh != 0) b = {58'd0, sh};
        else              b = v2;
        case (op)
            ADD:      return a + b;
            SUB:      return a - b;
            MUL:      return a * b;
            DIV: begin
                if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (a == INT64_MIN && b == -64'sd1) return a;
                return a / b;
            end
            REM: begin
                if (b == 0) return a;
                if (a == INT64_MIN && b == -64'sd1) return 64'd0;
                return a % b;
            end
            AND:      return a & b;
            OR:       return a | b;
            XOR:      return a ^ b;
            SLT:      return (a < b) ? 64'd1 : 64'd0;
            SHLEFT:   return a << b[5:0];
            LOGRIGHT: return a >> b[5:0];
            default:  return 64'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        if (op == MUL) return MUL_LAT;
        if (op == DIV || op == REM) return DIV_LAT;
        return 1;
    endfunction

    // Issue one op from requester id, stall the response rdly cycles, check everything.
    task automatic do_op(input int id, input logic [3:0] op, input logic [63:0] v1,
                         input logic [63:0] v2, input logic [31:0] imm, input logic [5:0] sh,
                         input int rdly, input logic [63:0] exp, input logic exp_ill,
                         input int exp_lat);
        int n;
        logic [IDW-1:0] sid;
        sid = id[IDW-1:0];
        @(negedge clk);
        req_opcode[sid] = op;
        req_value1[sid] = v1;
        req_value2[sid] = v2;
        req_imm[sid]    = imm;
        req_shamt[sid]  = sh;
        req_valid[sid]  = 1'b1;
        rsp_ready       = (rdly == 0);
        #1;
        n = 0;
        while (!req_ready[sid] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept", req_ready[sid], 1);
        if (!req_ready[sid]) begin
            req_valid[sid] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[sid] = 1'b0;
        check("busy_exec", busy, 1);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, exp_lat);
        if (!rsp_valid) return;
        for (int k = 0; k < rdly; k++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, exp);
            check("hold_busy", busy, 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("valid", rsp_valid, 1);
        check("result", rsp_result, exp);
        check("illegal", rsp_illegal, exp_ill);
        check("id", rsp_id, id);
        @(negedge clk);
        check("rsp_drop", rsp_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic arb_test();
        int prev;
        int ngr;
        int g;
        int e;
        int q[$];
        prev = -1;
        ngr  = 0;
        @(negedge clk);
        req_opcode[0] = ADD; req_value1[0] = 64'd5;   req_value2[0] = 64'd7;
        req_imm[0]    = '0;  req_shamt[0]  = '0;
        req_opcode[1] = ADD; req_value1[1] = 64'd100; req_value2[1] = 64'd1;
        req_imm[1]    = '0;  req_shamt[1]  = '0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (rsp_valid) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("arb_rsp_id", rsp_id, e);
                    check("arb_rsp_result", rsp_result, (e == 1) ? 64'd101 : 64'd12);
                end else begin
                    check("arb_spurious_rsp", rsp_valid, 0);
                end
            end
            if (busy) begin
                check("arb_no_grant_busy", req_ready, 0);
            end else if (req_ready != 0) begin
                g = req_ready[1] ? 1 : 0;
                check("arb_onehot", $countones(req_ready), 1);
                if (prev >= 0) check("arb_alternate", g, 1 - prev);
                prev = g;
                ngr++;
                q.push_back(g);
            end
            @(negedge clk);
        end
        req_valid = '0;
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        check("arb_drained", busy, 0);
        check("arb_grants_ge8", ngr >= 8, 1);
    endtask

    task automatic rand_test(input int nops);
        int          id;
        logic [3:0]  op;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [31:0] imm;
        logic [5:0]  sh;
        for (int i = 0; i < nops; i++) begin
            id = $urandom_range(0, NREQ - 1);
            op = 4'($urandom_range(0, 15));
            v1 = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) v1 = INT64_MIN;
            case ($urandom_range(0, 3))
                0:       v2 = 64'd0;
                1:       v2 = '1;
                2:       v2 = 64'($urandom_range(1, 20));
                default: v2 = {$urandom, $urandom};
            endcase
            imm = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            sh  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            do_op(id, op, v1, v2, imm, sh, $urandom_range(0, 2),
                  ref_result(op, v1, v2, imm, sh), op >= 4'd12, ref_lat(op));
        end
    endtask

    task automatic reset_test();
        int seen;
        seen = 0;
        @(negedge clk);
        req_opcode[0] = DIV; req_value1[0] = 64'd100; req_value2[0] = 64'd3;
        req_imm[0]    = '0;  req_shamt[0]  = '0;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        #1;
        check("rst_div_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("rst_pre_busy", busy, 1);
        req_opcode[1] = ADD; req_value1[1] = 64'd7; req_value2[1] = 64'd0;
        req_imm[1]    = '0;  req_shamt[1]  = '0;
        req_valid = 2'b11;
        reset = 1'b1;
        #1;
        check("rst_ready_forced0", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rst_no_rsp", seen, 0);
        req_opcode[0] = ADD; req_value1[0] = 64'd1; req_value2[0] = 64'd1;
        req_valid = 2'b11;
        #1;
        check("rst_ptr_to_req0", req_ready, 2'b01);
        req_valid = '0;
        do_op(0, ADD, 64'd1, 64'd1, 32'd0, 6'd0, 0, 64'd2, 1'b0, 1);
    endtask

    initial begin
        vecs[0]  = '{0, ADD, 64'd5, 64'd7, 32'd0, 6'd0, 0, 64'd12, 1'b0, 1};
        vecs[1]  = '{1, MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 32'd0, 6'd0, 5,
                     64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 3};
        vecs[2]  = '{0, DIV, 64'd10, 64'd0, 32'd0, 6'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8};
        vecs[3]  = '{1, REM, 64'd10, 64'd0, 32'd0, 6'd0, 0, 64'd10, 1'b0, 8};
        vecs[4]  = '{0, DIV, INT64_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 6'd0, 0, INT64_MIN, 1'b0, 8};
        vecs[5]  = '{1, REM, INT64_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 6'd0, 0, 64'd0, 1'b0, 8};
        vecs[6]  = '{0, 4'd13, 64'd3, 64'd4, 32'd0, 6'd0, 0, 64'd0, 1'b1, 1};
        vecs[7]  = '{1, NOTHING, 64'd3, 64'd4, 32'd0, 6'd0, 0, 64'd0, 1'b0, 1};
        vecs[8]  = '{0, SUB, 64'd10, 64'd99, 32'hFFFF_FFFB, 6'd0, 0, 64'd15, 1'b0, 1};
        vecs[9]  = '{1, ADD, 64'd1, 64'd100, 32'd0, 6'd3, 1, 64'd4, 1'b0, 1};
        vecs[10] = '{0, DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 32'd0, 6'd0, 0,
                     64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 8};
        vecs[11] = '{1, ARTHRIGHT, 64'd64, 64'd1, 32'd0, 6'd0, 0, 64'd0, 1'b1, 1};
        vecs[12] = '{0, REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 32'd0, 6'd0, 2,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8};
        vecs[13] = '{1, LOGRIGHT, INT64_MIN, 64'd0, 32'd0, 6'd4, 0,
                     64'h0800_0000_0000_0000, 1'b0, 1};

        reset      = 1'b1;
        req_valid  = '0;
        req_opcode = '0;
        req_value1 = '0;
        req_value2 = '0;
        req_imm    = '0;
        req_shamt  = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_rsp_illegal", rsp_illegal, 0);
        check("reset_busy", busy, 0);
        req_valid = '0;
        reset     = 1'b0;

        for (int i = 0; i < 14; i++)
            do_op(vecs[i].id, vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].imm, vecs[i].sh,
                  vecs[i].rdly, vecs[i].exp, vecs[i].ill, vecs[i].lat);

        arb_test();
        rand_test(40);
        reset_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
